// File: rtl/regfile_write_arbiter.sv
// Two-requester arbiter for the single RegFile write port, with a one-cycle
// registered write stage that is forwarded onto both read ports.
// Requester 0 (pipeline writeback) has priority; requester 1 (long-latency
// unit) is guaranteed access by a saturating starvation counter.
module regfile_write_arbiter #(
  parameter int unsigned DWIDTH       = 32,
  parameter int unsigned AWIDTH       = 5,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [AWIDTH-1:0] req0_addr,
  input  logic [DWIDTH-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [AWIDTH-1:0] req1_addr,
  input  logic [DWIDTH-1:0] req1_data,
  output logic              rf_we,
  output logic [AWIDTH-1:0] rf_wa,
  output logic [DWIDTH-1:0] rf_wd,
  input  logic [AWIDTH-1:0] ra1,
  input  logic [AWIDTH-1:0] ra2,
  input  logic [DWIDTH-1:0] rf_rd1,
  input  logic [DWIDTH-1:0] rf_rd2,
  output logic [DWIDTH-1:0] rd1,
  output logic [DWIDTH-1:0] rd2
);

  // Counter only needs to reach STARVE_LIMIT, where it saturates.
  localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0]  starve_cnt;
  logic [CNT_W-1:0]  starve_cnt_nxt;
  logic              boost;
  logic              xfer0;
  logic              xfer1;
  logic              wr_en_nxt;
  logic [AWIDTH-1:0] sel_addr;
  logic [DWIDTH-1:0] sel_data;

  // Grant logic: req0 wins unless req1 has been starved long enough.
  always_comb begin
    boost      = (starve_cnt >= CNT_MAX);
    req0_ready = ~rst & ~(boost & req1_valid);
    req1_ready = ~rst & (boost | ~req0_valid);
    xfer0      = req0_valid & req0_ready;
    xfer1      = req1_valid & req1_ready;
  end

  // Select the accepted write; writes to register 0 are accepted but dropped.
  always_comb begin
    sel_addr  = req0_addr;
    sel_data  = req0_data;
    if (xfer1) begin
      sel_addr = req1_addr;
      sel_data = req1_data;
    end
    wr_en_nxt = (xfer0 | xfer1) & (sel_addr != '0);
  end

  // Starvation counter: counts consecutive denied cycles of a pending req1.
  always_comb begin
    starve_cnt_nxt = '0;
    if (req1_valid & ~req1_ready) begin
      starve_cnt_nxt = (starve_cnt == CNT_MAX) ? starve_cnt : starve_cnt + CNT_W'(1);
    end
  end

  // Registered write stage toward the RegFile; address/data hold when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
      rf_we      <= 1'b0;
      rf_wa      <= '0;
      rf_wd      <= '0;
    end else begin
      starve_cnt <= starve_cnt_nxt;
      rf_we      <= wr_en_nxt;
      if (wr_en_nxt) begin
        rf_wa <= sel_addr;
        rf_wd <= sel_data;
      end
    end
  end

  // Forward the in-flight write so readers never see the stale RegFile value.
  always_comb begin
    rd1 = rf_rd1;
    rd2 = rf_rd2;
    if (rf_we && (rf_wa == ra1) && (ra1 != '0)) rd1 = rf_wd;
    if (rf_we && (rf_wa == ra2) && (ra2 != '0)) rd2 = rf_wd;
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with a behavioural RegFile model.
module tb_regfile_write_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req0_ready;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_data;
  logic          req1_valid, req1_ready;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_data;
  logic          rf_we;
  logic [AW-1:0] rf_wa;
  logic [DW-1:0] rf_wd;
  logic [AW-1:0] ra1, ra2;
  logic [DW-1:0] rf_rd1, rf_rd2;
  logic [DW-1:0] rd1, rd2;

  logic [DW-1:0] rf_mem [32];

  int pass_cnt = 0;
  int chk_cnt  = 0;

  always #5 clk = ~clk;

  regfile_write_arbiter #(.DWIDTH(DW), .AWIDTH(AW), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_data(req1_data),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .ra1(ra1), .ra2(ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .rd1(rd1), .rd2(rd2)
  );

  // External RegFile model: async read, write at rising edge, x0 hardwired to 0.
  assign rf_rd1 = rf_mem[ra1];
  assign rf_rd2 = rf_mem[ra2];
  always @(posedge clk) begin
    if (rf_we && rf_wa != '0) rf_mem[rf_wa] <= rf_wd;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'h11;
    req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 32'h22;
    ra1 = '0; ra2 = '0;
    for (int c = 0; c < 2; c++) begin
      tick();
      chk_cnt++; if (req0_ready !== 1'b0) $display("FAIL rst_r0 c%0d got %b exp 0", c, req0_ready); else pass_cnt++;
      chk_cnt++; if (req1_ready !== 1'b0) $display("FAIL rst_r1 c%0d got %b exp 0", c, req1_ready); else pass_cnt++;
    end
    chk_cnt++; if (rf_we !== 1'b0) $display("FAIL rst_we got %b exp 0", rf_we); else pass_cnt++;
    chk_cnt++; if (rf_wa !== 5'd0) $display("FAIL rst_wa got %h exp 0", rf_wa); else pass_cnt++;
    chk_cnt++; if (rf_wd !== 32'd0) $display("FAIL rst_wd got %h exp 0", rf_wd); else pass_cnt++;
    rst = 1'b0;
    idle();
    tick();
    chk_cnt++; if (rf_we !== 1'b0) $display("FAIL post_rst_we got %b exp 0", rf_we); else pass_cnt++;
  endtask

  task automatic test_single_write();
    req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'hDEADBEEF;
    ra1 = 5'd3;
    #1;
    chk_cnt++; if (req0_ready !== 1'b1) $display("FAIL single_r0 got %b exp 1", req0_ready); else pass_cnt++;
    chk_cnt++; if (rd1 !== 32'd0) $display("FAIL single_pre_rd1 got %h exp 0", rd1); else pass_cnt++;
    tick();
    idle();
    #1;
    chk_cnt++; if (rf_we !== 1'b1) $display("FAIL single_we got %b exp 1", rf_we); else pass_cnt++;
    chk_cnt++; if (rf_wa !== 5'd3) $display("FAIL single_wa got %h exp 3", rf_wa); else pass_cnt++;
    chk_cnt++; if (rf_wd !== 32'hDEADBEEF) $display("FAIL single_wd got %h exp deadbeef", rf_wd); else pass_cnt++;
    chk_cnt++; if (rd1 !== 32'hDEADBEEF) $display("FAIL single_fwd_rd1 got %h exp deadbeef", rd1); else pass_cnt++;
    tick();
    chk_cnt++; if (rf_we !== 1'b0) $display("FAIL single_we_n2 got %b exp 0", rf_we); else pass_cnt++;
    chk_cnt++; if (rd1 !== 32'hDEADBEEF) $display("FAIL single_raw_rd1 got %h exp deadbeef", rd1); else pass_cnt++;
  endtask

  task automatic test_contention();
    int idx0 = 0;
    bit pend1 = 1'b1;
    bit e_r0 [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    bit e_r1 [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    int e_wa [9] = '{1, 2, 3, 4, 9, 5, 6, 7, 8};
    logic [DW-1:0] e_wd;
    for (int c = 0; c < 9; c++) begin
      req0_valid = 1'b1; req0_addr = AW'(idx0 + 1); req0_data = 32'h100 + DW'(idx0);
      req1_valid = pend1; req1_addr = 5'd9; req1_data = 32'hA5A50009;
      #1;
      chk_cnt++; if (req0_ready !== e_r0[c]) $display("FAIL cont_r0 c%0d got %b exp %b", c, req0_ready, e_r0[c]); else pass_cnt++;
      chk_cnt++; if (req1_ready !== e_r1[c]) $display("FAIL cont_r1 c%0d got %b exp %b", c, req1_ready, e_r1[c]); else pass_cnt++;
      if (e_r1[c]) pend1 = 1'b0;
      else if (e_r0[c]) idx0++;
      tick();
      e_wd = (e_wa[c] == 9) ? 32'hA5A50009 : 32'h100 + DW'(e_wa[c] - 1);
      chk_cnt++; if (rf_we !== 1'b1) $display("FAIL cont_we c%0d got %b exp 1", c, rf_we); else pass_cnt++;
      chk_cnt++; if (rf_wa !== AW'(e_wa[c])) $display("FAIL cont_wa c%0d got %0d exp %0d", c, rf_wa, e_wa[c]); else pass_cnt++;
      chk_cnt++; if (rf_wd !== e_wd) $display("FAIL cont_wd c%0d got %h exp %h", c, rf_wd, e_wd); else pass_cnt++;
    end
    idle();
    tick();
  endtask

  task automatic test_x0_write();
    logic [AW-1:0] prev_wa;
    prev_wa = rf_wa;
    req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'd5;
    ra1 = 5'd0;
    #1;
    chk_cnt++; if (req1_ready !== 1'b1) $display("FAIL x0_r1 got %b exp 1", req1_ready); else pass_cnt++;
    tick();
    idle();
    #1;
    chk_cnt++; if (rf_we !== 1'b0) $display("FAIL x0_we got %b exp 0", rf_we); else pass_cnt++;
    chk_cnt++; if (rf_wa !== prev_wa) $display("FAIL x0_wa_hold got %h exp %h", rf_wa, prev_wa); else pass_cnt++;
    chk_cnt++; if (rd1 !== 32'd0) $display("FAIL x0_rd1 got %h exp 0", rd1); else pass_cnt++;
    tick();
  endtask

  task automatic test_back_to_back();
    ra1 = 5'd7; ra2 = 5'd7;
    req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'd1;
    tick();
    req0_data = 32'd2;
    #1;
    chk_cnt++; if (rf_wd !== 32'd1) $display("FAIL b2b_wd1 got %h exp 1", rf_wd); else pass_cnt++;
    chk_cnt++; if (rd1 !== 32'd1) $display("FAIL b2b_rd1_a got %h exp 1", rd1); else pass_cnt++;
    chk_cnt++; if (rd2 !== 32'd1) $display("FAIL b2b_rd2_a got %h exp 1", rd2); else pass_cnt++;
    tick();
    idle();
    #1;
    chk_cnt++; if (rf_wd !== 32'd2) $display("FAIL b2b_wd2 got %h exp 2", rf_wd); else pass_cnt++;
    chk_cnt++; if (rd1 !== 32'd2) $display("FAIL b2b_rd1_b got %h exp 2", rd1); else pass_cnt++;
    chk_cnt++; if (rd2 !== 32'd2) $display("FAIL b2b_rd2_b got %h exp 2", rd2); else pass_cnt++;
    tick();
    chk_cnt++; if (rf_we !== 1'b0) $display("FAIL b2b_we_c got %b exp 0", rf_we); else pass_cnt++;
    chk_cnt++; if (rd1 !== 32'd2) $display("FAIL b2b_raw_rd1 got %h exp 2", rd1); else pass_cnt++;
    chk_cnt++; if (rd2 !== 32'd2) $display("FAIL b2b_raw_rd2 got %h exp 2", rd2); else pass_cnt++;
  endtask

  task automatic test_reset_mid_starve();
    int idx0 = 0;
    ra1 = 5'd0; ra2 = 5'd0;
    req1_valid = 1'b1; req1_addr = 5'd20; req1_data = 32'h14;
    // Build starve count of 3.
    for (int c = 0; c < 3; c++) begin
      req0_valid = 1'b1; req0_addr = AW'(10 + idx0); req0_data = 32'h200 + DW'(idx0);
      #1;
      chk_cnt++; if (req0_ready !== 1'b1) $display("FAIL mid_pre_r0 c%0d got %b exp 1", c, req0_ready); else pass_cnt++;
      chk_cnt++; if (req1_ready !== 1'b0) $display("FAIL mid_pre_r1 c%0d got %b exp 0", c, req1_ready); else pass_cnt++;
      idx0++;
      tick();
    end
    // Reset cycle while the write to r12 sits on rf_we.
    req0_addr = AW'(10 + idx0); req0_data = 32'h200 + DW'(idx0);
    rst = 1'b1;
    #1;
    chk_cnt++; if (req0_ready !== 1'b0) $display("FAIL mid_rst_r0 got %b exp 0", req0_ready); else pass_cnt++;
    chk_cnt++; if (req1_ready !== 1'b0) $display("FAIL mid_rst_r1 got %b exp 0", req1_ready); else pass_cnt++;
    chk_cnt++; if (rf_wa !== 5'd12) $display("FAIL mid_rst_wa got %0d exp 12", rf_wa); else pass_cnt++;
    tick();
    rst = 1'b0;
    ra1 = 5'd12;
    #1;
    chk_cnt++; if (rf_we !== 1'b0) $display("FAIL mid_post_we got %b exp 0", rf_we); else pass_cnt++;
    chk_cnt++; if (rd1 !== 32'h202) $display("FAIL mid_commit_rd1 got %h exp 202", rd1); else pass_cnt++;
    // Counter restarted: req0 wins four more cycles before req1.
    for (int c = 0; c < 5; c++) begin
      req0_valid = 1'b1; req0_addr = AW'(10 + idx0); req0_data = 32'h200 + DW'(idx0);
      #1;
      chk_cnt++; if (req0_ready !== (c < 4)) $display("FAIL mid_r0 c%0d got %b exp %b", c, req0_ready, (c < 4)); else pass_cnt++;
      chk_cnt++; if (req1_ready !== (c == 4)) $display("FAIL mid_r1 c%0d got %b exp %b", c, req1_ready, (c == 4)); else pass_cnt++;
      if (c < 4) idx0++;
      tick();
    end
    req1_valid = 1'b0;
    #1;
    chk_cnt++; if (rf_wa !== 5'd20) $display("FAIL mid_grant_wa got %0d exp 20", rf_wa); else pass_cnt++;
    chk_cnt++; if (rf_wd !== 32'h14) $display("FAIL mid_grant_wd got %h exp 14", rf_wd); else pass_cnt++;
    idle();
    tick();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf_mem[i] = '0;
    idle();
    test_reset();
    test_single_write();
    test_contention();
    test_x0_write();
    test_back_to_back();
    test_reset_mid_starve();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
